// File: rtl/sba_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sba_pkg: shared states, frame byte codes and SBA widths              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sba_pkg;

  localparam int ADDR_W = 32;
  localparam int DAT_W  = 32;
  localparam int WE_W   = 4;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    REQ  = 3'd3,
    BUS  = 3'd4,
    GAP  = 3'd5,
    RESP = 3'd6
  } state_e;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sba_dbg_master_byte_shift32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_shift32: 4-byte little-endian shift register with byte count    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module byte_shift32 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_done
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // First byte received ends up in bits [7:0] after four shifts.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (i_clr) begin
      cnt_d = 2'd0;
    end else if (i_en) begin
      word_d = {i_byte, word_q[31:8]};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_word = word_q;
  assign o_done = i_en && !i_clr && (cnt_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/sba_dbg_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sba_dbg_master: byte-framed command decoder driving one SBA access   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sba_dbg_master
  import sba_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned FRAME_TO = 65535,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_dat,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_dat,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_req,
  input  logic              i_gnt,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DAT_W-1:0]  o_dat_w,
  output logic [WE_W-1:0]   o_we,
  output logic              o_stb,
  input  logic [DAT_W-1:0]  i_dat_r,
  input  logic              i_ack,
  output logic              o_busy,
  output logic              o_err
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FR_LAST = CNT_W'(FRAME_TO - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DAT_W-1:0]  rdata_q, rdata_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        tx_dat_q, tx_dat_d;
  logic              tx_valid_q, tx_valid_d;
  logic              req_q, req_d;
  logic              stb_q, stb_d;
  logic [WE_W-1:0]   we_q, we_d;
  logic              err_q, err_d;

  logic              sh_clr, addr_en, data_en, addr_done, data_done;

  byte_shift32 u_addr_sh (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (sh_clr),
    .i_en   (addr_en),
    .i_byte (i_rx_dat),
    .o_word (o_addr),
    .o_done (addr_done)
  );

  byte_shift32 u_data_sh (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (sh_clr),
    .i_en   (data_en),
    .i_byte (i_rx_dat),
    .o_word (o_dat_w),
    .o_done (data_done)
  );

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    rsp_err_d  = rsp_err_q;
    rdata_d    = rdata_q;
    idx_d      = idx_q;
    tx_dat_d   = tx_dat_q;
    tx_valid_d = tx_valid_q;
    req_d      = req_q;
    stb_d      = stb_q;
    we_d       = we_q;
    err_d      = err_q;
    sh_clr     = 1'b0;
    addr_en    = 1'b0;
    data_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_rx_valid && (i_rx_dat == CMD_WR || i_rx_dat == CMD_RD)) begin
          is_wr_d = (i_rx_dat == CMD_WR);
          sh_clr  = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (i_rx_valid) begin
          addr_en = 1'b1;
          if (addr_done) begin
            state_d = is_wr_q ? DATA : REQ;
            req_d   = !is_wr_q;
          end
        end else if (cnt_q == FR_LAST) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (i_rx_valid) begin
          data_en = 1'b1;
          if (data_done) begin
            state_d = REQ;
            req_d   = 1'b1;
          end
        end else if (cnt_q == FR_LAST) begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (i_gnt) begin
          state_d = BUS;
          stb_d   = 1'b1;
          we_d    = is_wr_q ? {WE_W{1'b1}} : {WE_W{1'b0}};
        end
      end
      BUS: begin
        // Grant is guaranteed held while requesting, so i_gnt is not rechecked here.
        if (i_ack) begin
          rdata_d   = i_dat_r;
          rsp_err_d = 1'b0;
          stb_d     = 1'b0;
          we_d      = '0;
          state_d   = GAP;
        end else if (cnt_q == TO_LAST) begin
          rsp_err_d = 1'b1;
          err_d     = 1'b1;
          stb_d     = 1'b0;
          we_d      = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        state_d    = RESP;
        tx_valid_d = 1'b1;
        idx_d      = 2'd0;
        tx_dat_d   = rsp_err_q ? RSP_ERR : (is_wr_q ? RSP_OK : rdata_q[7:0]);
      end
      RESP: begin
        if (i_tx_ready) begin
          if (rsp_err_q || is_wr_q || idx_q == 2'd3) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_dat_d   = 8'h00;
            req_d      = 1'b0;
          end else begin
            idx_d    = idx_q + 2'd1;
            tx_dat_d = byte_sel(rdata_q, idx_q + 2'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Saturating counter, restarted by every state entry and every received frame byte.
    cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    if (state_d != state_q || ((state_q == ADDR || state_q == DATA) && i_rx_valid)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      rsp_err_q  <= 1'b0;
      rdata_q    <= '0;
      idx_q      <= '0;
      tx_dat_q   <= '0;
      tx_valid_q <= 1'b0;
      req_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      rsp_err_q  <= rsp_err_d;
      rdata_q    <= rdata_d;
      idx_q      <= idx_d;
      tx_dat_q   <= tx_dat_d;
      tx_valid_q <= tx_valid_d;
      req_q      <= req_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      err_q      <= err_d;
    end
  end

  assign o_tx_dat   = tx_dat_q;
  assign o_tx_valid = tx_valid_q;
  assign o_req      = req_q;
  assign o_stb      = stb_q;
  assign o_we       = we_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sba_dbg_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sba_dbg_master: scoreboard bench with arbiter, responder and sink |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sba_dbg_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_dat = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  o_tx_dat;
  logic        o_tx_valid;
  logic        tx_ready = 1'b1;
  logic        o_req;
  logic        gnt = 1'b0;
  logic [31:0] o_addr, o_dat_w;
  logic [3:0]  o_we;
  logic        o_stb;
  logic [31:0] dat_r = 32'h0;
  logic        ack = 1'b0;
  logic        o_busy, o_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] mem [logic [31:0]];

  logic resp_en = 1'b1;
  logic toggle_rdy = 1'b0;
  logic chk_req_low = 1'b0;
  logic req_seen = 1'b0;
  int   req_cycles = 0;
  int   stb_run = 0, last_run = 0, stb_periods = 0;

  always #5 clk = ~clk;

  sba_dbg_master #(.TIMEOUT(16), .FRAME_TO(32), .CNT_W(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_rx_dat   (rx_dat),
    .i_rx_valid (rx_valid),
    .o_tx_dat   (o_tx_dat),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (tx_ready),
    .o_req      (o_req),
    .i_gnt      (gnt),
    .o_addr     (o_addr),
    .o_dat_w    (o_dat_w),
    .o_we       (o_we),
    .o_stb      (o_stb),
    .i_dat_r    (dat_r),
    .i_ack      (ack),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Arbiter, registered-ack responder and sink, all acting on last cycle's DUT outputs.
  initial begin
    logic        s_stb, s_req;
    logic [3:0]  s_we;
    logic [31:0] s_addr, s_dat;
    forever begin
      @(negedge clk);
      s_stb = o_stb; s_req = o_req; s_we = o_we; s_addr = o_addr; s_dat = o_dat_w;
      @(posedge clk);
      #1;
      req_cycles = s_req ? req_cycles + 1 : 0;
      gnt = s_req && (req_cycles >= 3);
      if (s_stb && s_we == 4'hF && !ack && resp_en) mem[s_addr] = s_dat;
      if (s_stb && resp_en) dat_r = mem.exists(s_addr) ? mem[s_addr] : 32'h0;
      ack = resp_en && s_stb;
      tx_ready = toggle_rdy ? ~tx_ready : 1'b1;
    end
  end

  // Output monitor: pops expected response bytes and checks hold and gap rules.
  initial begin
    logic       p_stb = 1'b0, p_valid = 1'b0, p_ready = 1'b0;
    logic [7:0] p_dat = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (chk_req_low) begin
          chk("req_low_after_rsp", {31'd0, o_req}, 32'd0);
          chk_req_low = 1'b0;
        end
        if (p_stb && !o_stb) chk("gap_cycle", {31'd0, o_tx_valid}, 32'd0);
        if (p_valid && !p_ready) begin
          chk("tx_hold_valid", {31'd0, o_tx_valid}, 32'd1);
          chk("tx_hold_dat", {24'd0, o_tx_dat}, {24'd0, p_dat});
        end
        if (o_tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            chk("tx_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", {24'd0, o_tx_dat}, {24'd0, e});
            if (exp_q.size() == 0) chk_req_low = 1'b1;
          end
        end
        if (o_req) req_seen = 1'b1;
        if (o_stb) stb_run++;
        else if (stb_run > 0) begin
          last_run = stb_run; stb_periods++; stb_run = 0;
        end
      end else if (stb_run > 0) begin
        last_run = stb_run; stb_periods++; stb_run = 0;
      end
      p_stb = o_stb; p_valid = o_tx_valid; p_ready = tx_ready; p_dat = o_tx_dat;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_dat = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_wr(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic send_rd(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_stb(input int max_cyc);
    int n = 0;
    while (!o_stb && n < max_cyc) begin @(negedge clk); n++; end
    if (!o_stb) chk("wait_stb_timeout", {31'd0, o_stb}, 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    @(negedge clk);
    while ((o_busy || exp_q.size() != 0) && n < max_cyc) begin @(negedge clk); n++; end
    if (o_busy || exp_q.size() != 0) chk("wait_idle_timeout", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    int p0;
    mem[32'h0000_0004] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("rst_stb", {31'd0, o_stb}, 32'd0);
    chk("rst_req", {31'd0, o_req}, 32'd0);
    chk("rst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_addr", o_addr, 32'd0);
    rst_n = 1'b1;

    // Firmware-style write to SRAM base.
    p0 = stb_periods;
    exp_q.push_back(8'h4B);
    send_wr(32'h8000_0000, 32'hDEAD_BEEF);
    wait_stb(50);
    chk("wr_addr", o_addr, 32'h8000_0000);
    chk("wr_dat", o_dat_w, 32'hDEAD_BEEF);
    chk("wr_we", {28'd0, o_we}, 32'hF);
    wait_idle(100);
    chk("wr_stb_periods", 32'(stb_periods - p0), 32'd1);

    // Read with a stalling sink.
    toggle_rdy = 1'b1;
    push_word(32'h1234_5678);
    send_rd(32'h0000_0004);
    wait_stb(50);
    chk("rd_addr", o_addr, 32'h4);
    chk("rd_we", {28'd0, o_we}, 32'h0);
    wait_idle(100);
    toggle_rdy = 1'b0;

    // Bus timeout with a silent responder.
    resp_en = 1'b0;
    exp_q.push_back(8'h45);
    send_rd(32'h3000_0000);
    wait_idle(100);
    chk("to_stb_len", 32'(last_run), 32'd16);
    chk("to_err", {31'd0, o_err}, 32'd1);
    resp_en = 1'b1;

    // Garbage bytes, then a partial frame left to expire.
    req_seen = 1'b0;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h41);
    @(negedge clk);
    chk("garbage_busy", {31'd0, o_busy}, 32'd0);
    send_byte(8'h57); send_byte(8'h01);
    repeat (10) @(negedge clk);
    chk("partial_busy", {31'd0, o_busy}, 32'd1);
    repeat (40) @(negedge clk);
    chk("frame_to_busy", {31'd0, o_busy}, 32'd0);
    chk("frame_to_no_req", {31'd0, req_seen}, 32'd0);
    push_word(32'h1234_5678);
    send_rd(32'h0000_0004);
    wait_idle(100);

    // Asynchronous reset while the strobe is up.
    resp_en = 1'b0;
    send_wr(32'h0000_0010, 32'h1122_3344);
    wait_stb(50);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stb", {31'd0, o_stb}, 32'd0);
    chk("arst_req", {31'd0, o_req}, 32'd0);
    chk("arst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
    chk("arst_err", {31'd0, o_err}, 32'd0);
    exp_q.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    resp_en = 1'b1;
    exp_q.push_back(8'h4B);
    send_wr(32'h0000_0020, 32'hCAFE_F00D);
    wait_idle(100);

    // Write then read back the same BRAM word.
    exp_q.push_back(8'h4B);
    send_wr(32'h0000_0040, 32'hA5A5_5A5A);
    wait_idle(100);
    push_word(32'hA5A5_5A5A);
    send_rd(32'h0000_0040);
    wait_idle(100);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
